// File: rtl/ir_cmd_queue.sv
// IR remote command queue: edge-detects decoded IR frames, validates and maps
// them to navigation commands, and buffers the commands in a small FIFO.
module ir_cmd_queue #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLDOFF    = 2500000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ir_data_ready,
  input  logic [31:0] ir_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [7:0]  cmd_ascii,
  output logic [7:0]  last_ascii,
  output logic        toggle_up,
  output logic        toggle_down,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [2:0] CODE_UP   = 3'd1;
  localparam logic [2:0] CODE_DOWN = 3'd2;

  logic [1:0]    state, state_nxt;
  logic          prev;
  logic          evt_q;
  logic [31:0]   frame_q;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          frame_ok_c;
  logic [2:0]    key_code_c;
  logic [7:0]    key_ascii_c;
  logic          accept_c;
  logic          reject_c;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          unused_frame_lo;

  // Command code to display character
  function automatic logic [7:0] ascii_of(input logic [2:0] code);
    case (code)
      3'd1:    ascii_of = 8'h32;
      3'd2:    ascii_of = 8'h38;
      3'd3:    ascii_of = 8'h36;
      3'd4:    ascii_of = 8'h34;
      3'd5:    ascii_of = 8'h35;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  // The low half of the frame carries the address and plays no part in decoding
  assign unused_frame_lo = ^frame_q[15:0];

  // Frame validation and key map
  always_comb begin
    key_code_c = 3'd0;
    frame_ok_c = (frame_q[31:24] == ~frame_q[23:16]) && (frame_q[23:20] == 4'h0);
    case (frame_q[19:16])
      4'h2:    key_code_c = 3'd1;
      4'h8:    key_code_c = 3'd2;
      4'h6:    key_code_c = 3'd3;
      4'h4:    key_code_c = 3'd4;
      4'h5:    key_code_c = 3'd5;
      default: key_code_c = 3'd0;
    endcase
    key_ascii_c = ascii_of(key_code_c);
    accept_c    = (state == S_DECODE) && frame_ok_c && (key_code_c != 3'd0);
    reject_c    = (state == S_DECODE) && !(frame_ok_c && (key_code_c != 3'd0));
  end

  // Queue handshake and head outputs
  always_comb begin
    cmd_valid = (count != CW'(0));
    full_c    = (count == CW'(FIFO_DEPTH));
    pop_c     = cmd_valid && cmd_ready;
    push_c    = accept_c && (!full_c || pop_c);
    cmd_code  = cmd_valid ? mem[rd_ptr] : 3'd0;
    cmd_ascii = ascii_of(cmd_code);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (evt_q) state_nxt = S_DECODE;
      S_DECODE: state_nxt = accept_c ? S_HOLD : S_IDLE;
      S_HOLD:   if (hold_cnt == HW'(0)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Edge detect (registered so the FSM acts one edge after sampling), frame capture, holdoff timer
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prev     <= 1'b0;
      evt_q    <= 1'b0;
      frame_q  <= 32'd0;
      hold_cnt <= HW'(0);
    end else begin
      prev  <= ir_data_ready;
      evt_q <= ir_data_ready && !prev && (state == S_IDLE);
      if ((state == S_IDLE) && evt_q) frame_q <= ir_data;
      if (accept_c)
        hold_cnt <= HW'(HOLDOFF - 1);
      else if ((state == S_HOLD) && (hold_cnt != HW'(0)))
        hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push_c) mem[wr_ptr] <= key_code_c;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      count  <= CW'(0);
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (!push_c && pop_c) count <= count - CW'(1);
    end
  end

  // LCD character, key toggles and sticky error status
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_ascii  <= 8'h00;
      toggle_up   <= 1'b0;
      toggle_down <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      if (accept_c) begin
        last_ascii <= key_ascii_c;
        if (key_code_c == CODE_UP)   toggle_up   <= ~toggle_up;
        if (key_code_c == CODE_DOWN) toggle_down <= ~toggle_down;
        if (!push_c) overflow <= 1'b1;
      end
      if (reject_c && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ir_cmd_queue.sv
// Directed bench for ir_cmd_queue with a scoreboard of expected queued commands.
module tb_ir_cmd_queue;

  localparam int unsigned HOLDOFF = 8;

  logic        clock;
  logic        resetn;
  logic        ir_data_ready;
  logic [31:0] ir_data;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [7:0]  cmd_ascii;
  logic [7:0]  last_ascii;
  logic        toggle_up;
  logic        toggle_down;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];

  ir_cmd_queue #(.FIFO_DEPTH(4), .HOLDOFF(HOLDOFF)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .ir_data_ready (ir_data_ready),
    .ir_data       (ir_data),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_ascii     (cmd_ascii),
    .last_ascii    (last_ascii),
    .toggle_up     (toggle_up),
    .toggle_down   (toggle_down),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ascii(input logic [2:0] c);
    case (c)
      3'd1:    exp_ascii = 8'h32;
      3'd2:    exp_ascii = 8'h38;
      3'd3:    exp_ascii = 8'h36;
      3'd4:    exp_ascii = 8'h34;
      3'd5:    exp_ascii = 8'h35;
      default: exp_ascii = 8'h00;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_code"},  32'(cmd_code), 32'd0);
    check({tag, "_ascii"}, 32'(cmd_ascii), 32'h00);
    check({tag, "_last"},  32'(last_ascii), 32'h00);
    check({tag, "_tup"},   32'(toggle_up), 32'd0);
    check({tag, "_tdn"},   32'(toggle_down), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  // Called at a negedge; rises ready, holds 2 cycles, leaves 12 cycles total
  task automatic send(input logic [31:0] d);
    ir_data       = d;
    ir_data_ready = 1'b1;
    repeat (2) @(negedge clock);
    ir_data_ready = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  // Pop every expected entry and compare against the scoreboard, then confirm empty
  task automatic drain(input string tag);
    logic [2:0] e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hvalid"}, 32'(cmd_valid), 32'd1);
      check({tag, "_hcode"},  32'(cmd_code), 32'(e));
      check({tag, "_hascii"}, 32'(cmd_ascii), 32'(exp_ascii(e)));
      cmd_ready = 1'b1;
      @(negedge clock);
      cmd_ready = 1'b0;
    end
    check({tag, "_empty_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_empty_code"},  32'(cmd_code), 32'd0);
    check({tag, "_empty_ascii"}, 32'(cmd_ascii), 32'h00);
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn        = 1'b0;
    ir_data_ready = 1'b0;
    ir_data       = 32'd0;
    cmd_ready     = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    check_reset("por");

    // a) single UP frame, latency and level-held ready
    ir_data       = 32'hFD02FF00;
    ir_data_ready = 1'b1;
    @(negedge clock);
    check("a_valid_N", 32'(cmd_valid), 32'd0);
    @(negedge clock);
    check("a_valid_N1", 32'(cmd_valid), 32'd0);
    @(negedge clock);
    check("a_valid_N2", 32'(cmd_valid), 32'd1);
    check("a_code", 32'(cmd_code), 32'd1);
    check("a_ascii", 32'(cmd_ascii), 32'h32);
    check("a_last", 32'(last_ascii), 32'h32);
    check("a_tup", 32'(toggle_up), 32'd1);
    sb.push_back(3'd1);
    repeat (3) @(negedge clock);
    ir_data_ready = 1'b0;
    repeat (6) @(negedge clock);
    drain("a");

    // b) rejected frames are counted, not queued
    send(32'hFC02FF00);
    check("b_drop1", 32'(drop_count), 32'd1);
    check("b_valid1", 32'(cmd_valid), 32'd0);
    send(32'hF807FF00);
    check("b_drop2", 32'(drop_count), 32'd2);
    check("b_valid2", 32'(cmd_valid), 32'd0);
    check("b_last", 32'(last_ascii), 32'h32);

    // c) five DOWN frames into a 4-deep queue with no consumer
    reset_dut();
    check_reset("c_rst");
    for (int i = 0; i < 5; i++) begin
      send(32'hF708FF00);
      if (i < 4) sb.push_back(3'd2);
    end
    check("c_ovf", 32'(overflow), 32'd1);
    check("c_tdn", 32'(toggle_down), 32'd1);
    check("c_drop", 32'(drop_count), 32'd0);
    check("c_last", 32'(last_ascii), 32'h38);
    drain("c");
    check("c_ovf_sticky", 32'(overflow), 32'd1);

    // d) full queue, push and pop on the same edge
    reset_dut();
    send(32'hFD02FF00); sb.push_back(3'd1);
    send(32'hF708FF00); sb.push_back(3'd2);
    send(32'hF906FF00); sb.push_back(3'd3);
    send(32'hFB04FF00); sb.push_back(3'd4);
    check("d_full_ovf", 32'(overflow), 32'd0);
    ir_data       = 32'hFA05FF00;
    ir_data_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready     = 1'b0;
    ir_data_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(3'd5);
    check("d_ovf", 32'(overflow), 32'd0);
    check("d_last", 32'(last_ascii), 32'h35);
    drain("d");
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    check("d_pop_empty", 32'(cmd_valid), 32'd0);
    repeat (8) @(negedge clock);

    // e) event during holdoff ignored, later event accepted
    ir_data       = 32'hFD02FF00;
    ir_data_ready = 1'b1;
    @(negedge clock);
    ir_data_ready = 1'b0;
    repeat (2) @(negedge clock);
    ir_data       = 32'hFB04FF00;
    ir_data_ready = 1'b1;
    @(negedge clock);
    ir_data_ready = 1'b0;
    repeat (8) @(negedge clock);
    sb.push_back(3'd1);
    send(32'hF906FF00);
    sb.push_back(3'd3);
    check("e_tup", 32'(toggle_up), 32'd0);
    check("e_last", 32'(last_ascii), 32'h36);
    check("e_drop", 32'(drop_count), 32'd0);
    drain("e");

    // f) reset during holdoff with two entries queued
    send(32'hFD02FF00);
    ir_data       = 32'hF708FF00;
    ir_data_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("f_pre_valid", 32'(cmd_valid), 32'd1);
    resetn        = 1'b0;
    ir_data_ready = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    sb.delete();
    check_reset("f_rst");
    send(32'hFB04FF00);
    sb.push_back(3'd4);
    check("f_code", 32'(cmd_code), 32'd4);
    check("f_ascii", 32'(cmd_ascii), 32'h34);
    check("f_last", 32'(last_ascii), 32'h34);
    drain("f");

    // drop_count saturation
    reset_dut();
    for (int i = 0; i < 255; i++) begin
      ir_data       = 32'hFC02FF00;
      ir_data_ready = 1'b1;
      @(negedge clock);
      ir_data_ready = 1'b0;
      repeat (3) @(negedge clock);
    end
    check("sat_255", 32'(drop_count), 32'd255);
    for (int i = 0; i < 5; i++) begin
      ir_data_ready = 1'b1;
      @(negedge clock);
      ir_data_ready = 1'b0;
      repeat (3) @(negedge clock);
    end
    check("sat_hold", 32'(drop_count), 32'd255);
    check("sat_valid", 32'(cmd_valid), 32'd0);
    check("sat_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
